// File: rtl/seq_ripple_subtractor_pkg.sv
// Shared constants and types for the slice-serial ripple-borrow subtractor.
// Imported by the top level and by the 4-bit slice.
package seq_ripple_subtractor_pkg;

  localparam int SLICE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the slice index register; never narrower than one bit.
  function automatic int idx_width(input int width);
    int n_slices;
    n_slices = width / SLICE;
    return (n_slices <= 1) ? 1 : $clog2(n_slices);
  endfunction

endpackage

// File: rtl/sub4_slice.sv
// Combinational 4-bit ripple-borrow subtractor slice: o_d = i_x - i_y - i_bin.
// Four full-subtractor cells, the borrow rippling from bit 0 upwards.
module sub4_slice
  import seq_ripple_subtractor_pkg::*;
(
  input  logic [SLICE-1:0] i_x,
  input  logic [SLICE-1:0] i_y,
  input  logic             i_bin,
  output logic [SLICE-1:0] o_d,
  output logic             o_bout
);

  logic [SLICE:0] w_borrow;

  assign w_borrow[0] = i_bin;

  for (genvar i = 0; i < SLICE; i++) begin : g_cell
    assign o_d[i]          = i_x[i] ^ i_y[i] ^ w_borrow[i];
    // Borrow when y exceeds x, or when they are equal and a borrow arrives.
    assign w_borrow[i + 1] = (~i_x[i] & i_y[i]) | (~(i_x[i] ^ i_y[i]) & w_borrow[i]);
  end

  assign o_bout = w_borrow[SLICE];

endmodule

// File: rtl/seq_ripple_subtractor.sv
// Multi-cycle WIDTH-bit subtractor (a - b - bin), one 4-bit slice per clock, LSB first.
// Handshake: start is taken only while ready=1; done is a one-cycle pulse with diff/bout/ovf valid.
module seq_ripple_subtractor
  import seq_ripple_subtractor_pkg::*;
#(
  parameter int WIDTH = 16
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  localparam int NSL = WIDTH / SLICE;
  localparam int IW  = idx_width(WIDTH);
  localparam int MSB = WIDTH - 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NSL - 1);

  if ((WIDTH % SLICE) != 0 || WIDTH < SLICE) begin : g_bad_width
    $error("seq_ripple_subtractor: WIDTH must be a positive multiple of SLICE");
  end

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_borrow;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;

  logic [SLICE-1:0] w_xs;
  logic [SLICE-1:0] w_ys;
  logic [SLICE-1:0] w_d;
  logic             w_bo;
  logic             w_last;

  assign w_xs   = r_a[int'(r_idx) * SLICE +: SLICE];
  assign w_ys   = r_b[int'(r_idx) * SLICE +: SLICE];
  assign w_last = (r_idx == LAST_IDX);

  sub4_slice u_slice (
    .i_x    (w_xs),
    .i_y    (w_ys),
    .i_bin  (r_borrow),
    .o_d    (w_d),
    .o_bout (w_bo)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_borrow <= 1'b0;
      r_idx    <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= bin;
            r_idx    <= '0;
          end
        end
        RUN: begin
          r_diff[int'(r_idx) * SLICE +: SLICE] <= w_d;
          r_borrow <= w_bo;
          r_idx    <= r_idx + 1'b1;
          // The top slice supplies both the final borrow and the result MSB.
          if (w_last) begin
            r_bout <= w_bo;
            r_ovf  <= (r_a[MSB] ^ r_b[MSB]) & (w_d[SLICE-1] ^ r_a[MSB]);
          end
        end
        default: ;
      endcase
    end
  end

  assign ready     = (r_state == IDLE);
  assign done      = (r_state == DONE);
  assign diff      = r_diff;
  assign bout      = r_bout;
  assign ovf       = r_ovf;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_ripple_subtractor.sv
// Directed bench for seq_ripple_subtractor (WIDTH=16): results, latency, handshake,
// ignored starts, mid-operation reset and back-to-back throughput.
module tb_seq_ripple_subtractor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        ready;
  logic        done;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [17:0] exp_q[$];

  always #5 clk = ~clk;

  seq_ripple_subtractor #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .ready     (ready),
    .done      (done),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation from IDLE and wait (bounded) for its done pulse.
  task automatic do_op(input logic [15:0] ia, input logic [15:0] ib, input logic ibin,
                       output int lat, output int rdy_low, output logic [17:0] res);
    a = ia; b = ib; bin = ibin; start = 1'b1;
    lat = 0; rdy_low = 0; res = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      start = 1'b0;
      lat++;
      if (!ready) rdy_low++;
      if (done) begin
        res = {ovf, bout, diff};
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = 16'h0; b = 16'h0; bin = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({ready, done, diff, bout, ovf} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got ready=%b done=%b diff=%h bout=%b ovf=%b, want 1 0 0000 0 0",
               ready, done, diff, bout, ovf);
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++; $display("FAIL reset_fsm_idle: got %0d want 0", dbg_state);
    end
    // rst and start together: start must be dropped.
    rst = 1'b1; start = 1'b1; a = 16'h1111; b = 16'h0001;
    tick();
    rst = 1'b0; start = 1'b0;
    checks++;
    if (ready !== 1'b1 || dbg_state !== 2'd0) begin
      errors++; $display("FAIL rst_beats_start: got ready=%b state=%0d want 1 0", ready, dbg_state);
    end
    begin
      int seen = 0;
      for (int i = 0; i < 7; i++) begin
        tick();
        if (done) seen++;
      end
      checks++;
      if (seen != 0) begin
        errors++; $display("FAIL rst_beats_start_no_done: got %0d done pulses want 0", seen);
      end
    end
  endtask

  task automatic test_basic();
    int lat, rl;
    logic [17:0] res;
    do_op(16'h1234, 16'h0234, 1'b0, lat, rl, res);
    checks++;
    if (lat != 5) begin errors++; $display("FAIL basic_latency: got %0d want 5", lat); end
    checks++;
    if (rl != 5) begin errors++; $display("FAIL basic_ready_low: got %0d want 5", rl); end
    checks++;
    if (res !== {1'b0, 1'b0, 16'h1000}) begin
      errors++; $display("FAIL basic_result: got %h want %h", res, {1'b0, 1'b0, 16'h1000});
    end
    tick();
    checks++;
    if (done !== 1'b0 || ready !== 1'b1) begin
      errors++; $display("FAIL basic_done_one_cycle: got done=%b ready=%b want 0 1", done, ready);
    end
    tick(); tick();
    checks++;
    if ({ovf, bout, diff} !== {1'b0, 1'b0, 16'h1000}) begin
      errors++; $display("FAIL basic_result_hold: got %h want %h", {ovf, bout, diff}, {1'b0, 1'b0, 16'h1000});
    end
  endtask

  task automatic test_borrow();
    int lat, rl;
    logic [17:0] res;
    do_op(16'h0000, 16'h0001, 1'b0, lat, rl, res);
    tick();
    checks++;
    if (res !== {1'b0, 1'b1, 16'hFFFF}) begin
      errors++; $display("FAIL borrow_0_minus_1: got %h want %h", res, {1'b0, 1'b1, 16'hFFFF});
    end
    do_op(16'h0005, 16'h0005, 1'b1, lat, rl, res);
    tick();
    checks++;
    if (res !== {1'b0, 1'b1, 16'hFFFF}) begin
      errors++; $display("FAIL borrow_bin_equal: got %h want %h", res, {1'b0, 1'b1, 16'hFFFF});
    end
  endtask

  task automatic test_overflow();
    int lat, rl;
    logic [17:0] res;
    do_op(16'h8000, 16'h0001, 1'b0, lat, rl, res);
    tick();
    checks++;
    if (res !== {1'b1, 1'b0, 16'h7FFF}) begin
      errors++; $display("FAIL ovf_neg_minus_pos: got %h want %h", res, {1'b1, 1'b0, 16'h7FFF});
    end
    do_op(16'h7FFF, 16'hFFFF, 1'b0, lat, rl, res);
    tick();
    checks++;
    if (res !== {1'b1, 1'b1, 16'h8000}) begin
      errors++; $display("FAIL ovf_pos_minus_neg: got %h want %h", res, {1'b1, 1'b1, 16'h8000});
    end
  endtask

  task automatic test_ignore_start();
    int seen;
    logic [17:0] res;
    seen = 0; res = '0;
    a = 16'h1000; b = 16'h0001; bin = 1'b0; start = 1'b1;
    tick();
    // RUN cycles 1-3: hammer start and scramble operands.
    for (int i = 0; i < 3; i++) begin
      a = 16'hFFFF; b = 16'h0000; bin = 1'b1; start = 1'b1;
      tick();
    end
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin seen++; res = {ovf, bout, diff}; end
      tick();
    end
    checks++;
    if (seen != 1) begin errors++; $display("FAIL ignore_single_done: got %0d want 1", seen); end
    checks++;
    if (res !== {1'b0, 1'b0, 16'h0FFF}) begin
      errors++; $display("FAIL ignore_first_operands: got %h want %h", res, {1'b0, 1'b0, 16'h0FFF});
    end
  endtask

  task automatic test_reset_mid_op();
    int seen, lat, rl;
    logic [17:0] res;
    seen = 0;
    a = 16'h0F0F; b = 16'h0101; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({done, diff, bout, ovf} !== {1'b0, 16'h0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL midrst_values: got done=%b diff=%h bout=%b ovf=%b want 0 0000 0 0",
                         done, diff, bout, ovf);
    end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", ready); end
    for (int i = 0; i < 8; i++) begin
      if (done) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL midrst_no_done: got %0d want 0", seen); end
    do_op(16'hABCD, 16'h1234, 1'b1, lat, rl, res);
    tick();
    checks++;
    if (lat != 5 || res !== {1'b0, 1'b0, 16'h9998}) begin
      errors++; $display("FAIL midrst_recover: got lat=%0d res=%h want 5 %h", lat, res, {1'b0, 1'b0, 16'h9998});
    end
  endtask

  task automatic test_back_to_back();
    int ndone, last_t, pushed;
    logic was_ready;
    logic [16:0] r;
    logic [17:0] exp_v;
    ndone = 0; last_t = -1; pushed = 0;
    a = 16'($urandom_range(0, 65535));
    b = 16'($urandom_range(0, 65535));
    bin = 1'($urandom_range(0, 1));
    start = 1'b1;
    for (int t = 0; t < 200 && ndone < 6; t++) begin
      was_ready = ready;
      tick();
      if (was_ready && start) begin
        r = {1'b0, a} - {1'b0, b} - {16'h0, bin};
        exp_q.push_back({(a[15] != b[15]) && (r[15] != a[15]), r[16], r[15:0]});
        pushed++;
        if (pushed < 6) begin
          a = 16'($urandom_range(0, 65535));
          b = 16'($urandom_range(0, 65535));
          bin = 1'($urandom_range(0, 1));
        end else begin
          start = 1'b0;
        end
      end
      if (done) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 18'h3FFFF;
        checks++;
        if ({ovf, bout, diff} !== exp_v) begin
          errors++; $display("FAIL b2b_result_%0d: got %h want %h", ndone, {ovf, bout, diff}, exp_v);
        end
        if (last_t >= 0) begin
          checks++;
          if (t - last_t != 6) begin
            errors++; $display("FAIL b2b_spacing_%0d: got %0d want 6", ndone, t - last_t);
          end
        end
        last_t = t;
        ndone++;
      end
    end
    start = 1'b0;
    checks++;
    if (ndone != 6) begin errors++; $display("FAIL b2b_timeout: got %0d done pulses want 6", ndone); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_overflow();
    test_ignore_start();
    test_reset_mid_op();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
